// File: rtl/row_render_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | row_render_stepper: per-line wall span walker with texv stepping/shading |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module row_render_stepper #(
  parameter int H_VIEW = 640,
  parameter int SIZE_W = 11,
  parameter int TEX_W  = 6,
  parameter int FRAC_W = 10,
  parameter int CH_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic                      side_in,
  input  logic [SIZE_W-1:0]         size_in,
  input  logic [TEX_W-1:0]          texu_in,
  input  logic [TEX_W+FRAC_W-1:0]   tex_init,
  input  logic [TEX_W+FRAC_W-1:0]   tex_step,
  input  logic [1:0]                mode,
  input  logic [9:0]                hpos,
  output logic                      hit,
  output logic [3*CH_W-1:0]         rgb,
  output logic [TEX_W-1:0]          texv
);

  localparam int HALF = H_VIEW / 2;
  localparam int AW   = TEX_W + FRAC_W;
  localparam int CW   = (SIZE_W + 1 > 11) ? SIZE_W + 1 : 11;

  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_LAST = CW'(H_VIEW - 1);
  localparam logic [CW-1:0] C_VIEW = CW'(H_VIEW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_WALL = 2'd2;
  localparam logic [1:0] S_POST = 2'd3;

  logic [1:0]        r_state;
  logic              r_side;
  logic [TEX_W-1:0]  r_texu;
  logic [AW-1:0]     r_init;
  logic [AW-1:0]     r_step;
  logic [AW-1:0]     r_acc;
  logic [CW-1:0]     r_ws;
  logic [CW-1:0]     r_we;
  logic              r_hit;
  logic [3*CH_W-1:0] r_rgb;
  logic [TEX_W-1:0]  r_texv;

  logic [CW-1:0]     w_size_x;
  logic [CW-1:0]     w_sum;
  logic [CW-1:0]     w_ws;
  logic [CW-1:0]     w_we;
  logic [CW-1:0]     w_hpos_x;
  logic              w_vis;
  logic [1:0]        w_state_nxt;
  logic [AW-1:0]     w_acc_nxt;
  logic              w_pix_hit;
  logic [TEX_W-1:0]  w_pix_texv;
  logic [3*CH_W-1:0] w_rgb_pix;
  logic              w_c0;
  logic              w_unused;

  // Span limits in SIZE_W+1 bits so HALF+size cannot overflow and HALF-size never underflows.
  assign w_size_x = CW'(size_in);
  assign w_sum    = C_HALF + w_size_x;
  assign w_ws     = (w_size_x > C_HALF) ? '0 : (C_HALF - w_size_x);
  assign w_we     = (w_sum > C_LAST) ? C_LAST : w_sum;
  assign w_hpos_x = CW'(hpos);
  assign w_vis    = (w_hpos_x < C_VIEW);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_pix_hit   = 1'b0;
    w_pix_texv  = '0;
    case (r_state)
      S_PRE: begin
        if (w_hpos_x == r_ws) begin
          w_pix_hit   = 1'b1;
          w_pix_texv  = r_init[AW-1 -: TEX_W];
          w_acc_nxt   = r_init + r_step;
          w_state_nxt = (r_ws == r_we) ? S_POST : S_WALL;
        end
      end
      S_WALL: begin
        if (!w_vis) begin
          w_state_nxt = S_POST;
        end else begin
          w_pix_hit  = 1'b1;
          w_pix_texv = r_acc[AW-1 -: TEX_W];
          w_acc_nxt  = r_acc + r_step;
          if (w_hpos_x == r_we) begin
            w_state_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        if (w_hpos_x >= C_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign w_c0 = r_texu[0] ^ w_pix_texv[0];

  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam int IX = (2 * c) % TEX_W;
    logic [CH_W-1:0] w_c;
    always_comb begin
      w_c = '0;
      case (mode)
        2'd0: begin
          w_c[CH_W-1] = 1'b1;
          if (r_side) w_c = '1;
        end
        2'd1: begin
          w_c[CH_W-1] = r_texu[IX] ^ w_pix_texv[IX];
          w_c[CH_W-2] = r_side;
        end
        2'd2: begin
          if (c == 1) begin
            w_c = {CH_W{w_c0}};
          end else if (c == 2) begin
            w_c[CH_W-1] = 1'b1;
            if (r_side) w_c = '1;
          end
        end
        default: w_c = w_pix_texv[TEX_W-1 -: CH_W];
      endcase
    end
    assign w_rgb_pix[c*CH_W +: CH_W] = w_c;
  end

  // Only a subset of texu bits feeds the shaders.
  assign w_unused = ^r_texu;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_side  <= 1'b0;
      r_texu  <= '0;
      r_init  <= '0;
      r_step  <= '0;
      r_acc   <= '0;
      r_ws    <= '0;
      r_we    <= '0;
      r_hit   <= 1'b0;
      r_rgb   <= '0;
      r_texv  <= '0;
    end else if (line_start) begin
      r_state <= S_PRE;
      r_side  <= side_in;
      r_texu  <= texu_in;
      r_init  <= tex_init;
      r_step  <= tex_step;
      r_acc   <= '0;
      r_ws    <= w_ws;
      r_we    <= w_we;
      r_hit   <= 1'b0;
      r_rgb   <= '0;
      r_texv  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_hit   <= w_pix_hit;
      r_texv  <= w_pix_texv;
      r_rgb   <= w_pix_hit ? w_rgb_pix : '0;
    end
  end

  assign hit  = r_hit;
  assign rgb  = r_rgb;
  assign texv = r_texv;

endmodule
`default_nettype wire

// File: tb/tb_row_render_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for row_render_stepper: default build plus a CH_W=3/TEX_W=7 build.
module tb_row_render_stepper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic        side_in = 1'b0;
  logic [10:0] size_in = '0;
  logic [5:0]  texu_in = '0;
  logic [15:0] tex_init = '0;
  logic [15:0] tex_step = '0;
  logic [1:0]  mode = 2'd1;
  logic [9:0]  hpos = '0;
  logic        hit;
  logic [5:0]  rgb;
  logic [5:0]  texv;

  logic [6:0]  texu2 = '0;
  logic [16:0] init2 = '0;
  logic [16:0] step2 = '0;
  logic        hit2;
  logic [8:0]  rgb2;
  logic [6:0]  texv2;

  int n_checks = 0;
  int n_pass   = 0;

  logic       o_hit  [800];
  logic [5:0] o_texv [800];
  logic [5:0] o_rgb  [800];
  logic       o_hit2 [800];
  logic [6:0] o_texv2[800];
  logic [8:0] o_rgb2 [800];

  row_render_stepper dut (
    .clk(clk), .reset(reset), .line_start(line_start), .side_in(side_in),
    .size_in(size_in), .texu_in(texu_in), .tex_init(tex_init), .tex_step(tex_step),
    .mode(mode), .hpos(hpos), .hit(hit), .rgb(rgb), .texv(texv)
  );

  row_render_stepper #(.CH_W(3), .TEX_W(7)) dut2 (
    .clk(clk), .reset(reset), .line_start(line_start), .side_in(side_in),
    .size_in(size_in), .texu_in(texu2), .tex_init(init2), .tex_step(step2),
    .mode(mode), .hpos(hpos), .hit(hit2), .rgb(rgb2), .texv(texv2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int sz, input logic sd, input logic [5:0] tu,
                      input logic [15:0] ti, input logic [15:0] ts);
    hpos = 10'd799;
    size_in = sz[10:0];
    side_in = sd;
    texu_in = tu;
    tex_init = ti;
    tex_step = ts;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Outputs seen #1 after the edge belong to the hpos sampled on that edge.
  task automatic sweep(input int from, input int to, input int lo, input int hi,
                       input logic [15:0] ti, input logic [15:0] ts, input string tag);
    int e_hit;
    int e_tv;
    for (int h = from; h <= to; h++) begin
      hpos = 10'(h);
      tick();
      o_hit[h] = hit;
      o_texv[h] = texv;
      o_rgb[h] = rgb;
      e_hit = (h >= lo && h <= hi) ? 1 : 0;
      e_tv = (e_hit != 0) ? ((((int'(ti) + (h - lo) * int'(ts)) % 65536) >> 10) & 63) : 0;
      check($sformatf("%s_hit@%0d", tag, h), 32'(hit), 32'(e_hit));
      check($sformatf("%s_texv@%0d", tag, h), 32'(texv), 32'(e_tv));
      if (e_hit == 0) check($sformatf("%s_rgb@%0d", tag, h), 32'(rgb), 32'd0);
    end
  endtask

  initial begin
    logic [6:0] tv2;
    logic [8:0] e_rgb2;
    int e2;

    reset = 1'b1;
    tick();
    tick();
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_texv", 32'(texv), 32'd0);
    reset = 1'b0;
    sweep(0, 799, 1000, -1, 16'd0, 16'd0, "idle");

    load(100, 1'b0, 6'd0, 16'd0, 16'd328);
    sweep(0, 799, 220, 420, 16'd0, 16'd328, "s100");
    check("s100_h219", 32'(o_hit[219]), 32'd0);
    check("s100_h220", 32'(o_hit[220]), 32'd1);
    check("s100_h420", 32'(o_hit[420]), 32'd1);
    check("s100_h421", 32'(o_hit[421]), 32'd0);
    check("s100_tv220", 32'(o_texv[220]), 32'd0);
    check("s100_tv419", 32'(o_texv[419]), 32'd63);
    check("s100_tv420", 32'(o_texv[420]), 32'd0);

    load(100, 1'b0, 6'd0, 16'd0, 16'd328);
    sweep(0, 250, 220, 420, 16'd0, 16'd328, "prerst");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hpos = 10'(251 + i);
      tick();
      check("midrst_hit", 32'(hit), 32'd0);
      check("midrst_rgb", 32'(rgb), 32'd0);
      check("midrst_texv", 32'(texv), 32'd0);
    end
    reset = 1'b0;
    sweep(254, 799, 1000, -1, 16'd0, 16'd0, "postrst");
    sweep(0, 799, 1000, -1, 16'd0, 16'd0, "idle2");

    load(0, 1'b1, 6'h2A, 16'(5 << 10), 16'd100);
    sweep(0, 799, 320, 320, 16'(5 << 10), 16'd100, "s0");
    check("s0_h320", 32'(o_hit[320]), 32'd1);
    check("s0_tv320", 32'(o_texv[320]), 32'd5);
    check("s0_h321", 32'(o_hit[321]), 32'd0);

    load(400, 1'b0, 6'd0, 16'(80 << 10), 16'd0);
    sweep(0, 799, 0, 639, 16'(80 << 10), 16'd0, "s400");
    check("s400_h0", 32'(o_hit[0]), 32'd1);
    check("s400_tv0", 32'(o_texv[0]), 32'd16);
    check("s400_h639", 32'(o_hit[639]), 32'd1);
    check("s400_h640", 32'(o_hit[640]), 32'd0);

    load(100, 1'b1, 6'b000101, 16'd0, 16'd0);
    for (int h = 0; h < 800; h++) begin
      case (h)
        301: mode = 2'd0;
        302: mode = 2'd2;
        303: mode = 2'd3;
        default: mode = 2'd1;
      endcase
      hpos = 10'(h);
      tick();
      o_rgb[h] = rgb;
    end
    mode = 2'd1;
    check("mode_blank219", 32'(o_rgb[219]), 32'd0);
    check("mode1", 32'(o_rgb[300]), 32'(6'b01_11_11));
    check("mode0", 32'(o_rgb[301]), 32'(6'b11_11_11));
    check("mode2", 32'(o_rgb[302]), 32'(6'b11_11_00));
    check("mode3", 32'(o_rgb[303]), 32'(6'b00_00_00));
    check("mode1b", 32'(o_rgb[304]), 32'(6'b01_11_11));

    load(50, 1'b0, 6'd0, 16'd0, 16'd0);
    sweep(0, 799, 270, 370, 16'd0, 16'd0, "s50");
    check("s50_h269", 32'(o_hit[269]), 32'd0);
    check("s50_h370", 32'(o_hit[370]), 32'd1);
    check("s50_h371", 32'(o_hit[371]), 32'd0);
    load(50, 1'b0, 6'd0, 16'd0, 16'd0);
    sweep(0, 349, 270, 370, 16'd0, 16'd0, "s50b");
    hpos = 10'd350;
    size_in = 11'd10;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    sweep(351, 799, 1000, -1, 16'd0, 16'd0, "abort");
    sweep(0, 799, 310, 330, 16'd0, 16'd0, "s10");
    check("s10_h309", 32'(o_hit[309]), 32'd0);
    check("s10_h310", 32'(o_hit[310]), 32'd1);
    check("s10_h330", 32'(o_hit[330]), 32'd1);
    check("s10_h331", 32'(o_hit[331]), 32'd0);

    texu2 = '0;
    init2 = '0;
    step2 = 17'(1 << 10);
    mode = 2'd3;
    load(64, 1'b0, 6'd0, 16'd0, 16'd0);
    for (int h = 0; h < 800; h++) begin
      hpos = 10'(h);
      tick();
      o_hit2[h] = hit2;
      o_texv2[h] = texv2;
      o_rgb2[h] = rgb2;
      e2 = (h >= 256 && h <= 384) ? 1 : 0;
      tv2 = (e2 != 0) ? 7'((h - 256) & 127) : 7'd0;
      e_rgb2 = (e2 != 0) ? {tv2[6:4], tv2[6:4], tv2[6:4]} : 9'd0;
      check($sformatf("w7_hit@%0d", h), 32'(hit2), 32'(e2));
      check($sformatf("w7_texv@%0d", h), 32'(texv2), 32'(tv2));
      check($sformatf("w7_rgb@%0d", h), 32'(rgb2), 32'(e_rgb2));
    end
    check("w7_tv256", 32'(o_texv2[256]), 32'd0);
    check("w7_tv383", 32'(o_texv2[383]), 32'd127);
    check("w7_tv384", 32'(o_texv2[384]), 32'd0);
    check("w7_rgb383", 32'(o_rgb2[383]), 32'h1FF);
    check("w7_rgb300", 32'(o_rgb2[300]), 32'h092);
    check("w7_h385", 32'(o_hit2[385]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/row_render_stepper.md
Name: row_render_stepper

Overview:
- Parametrised, pipelined successor to the combinational per-row wall renderer.
- Latches one trace line's wall data (side, size, texu, texv start and per-pixel texv step) during hblank. It then walks hpos across the visible span and generates hit, texture v and rgb with a fixed 1-cycle latency.
- Adds per-pixel texv stepping, selectable shading modes and configurable colour depth and texture size.
- Sits between the tracer (which supplies per-line size/step) and the final pixel mux.

Parameters:
- H_VIEW, 640, visible pixels per line; HALF = H_VIEW/2.
- SIZE_W, 11, width of size_in.
- TEX_W, 6, texture coordinate bits (texture is 2^TEX_W square).
- FRAC_W, 10, fractional bits of the texv accumulator and step.
- CH_W, 2, bits per colour channel; rgb is 3*CH_W wide, BBGGRR order.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle load strobe; asserted only while hpos >= H_VIEW.
- side_in  in  1  wall side for the line.
- size_in  in  SIZE_W  wall half-height, mirrored about HALF.
- texu_in  in  TEX_W  texture u for the line.
- tex_init  in  TEX_W+FRAC_W  texv fixed-point value at the first wall pixel.
- tex_step  in  TEX_W+FRAC_W  texv increment per pixel (unsigned fixed point).
- mode  in  2  shading mode, sampled every cycle (not latched).
- hpos  in  10  current horizontal position; increments by 1 per clk across the visible span.
- hit  out  1  registered: pixel hpos(t-1) is inside the wall.
- rgb  out  3*CH_W  registered pixel colour for hpos(t-1).
- texv  out  TEX_W  registered integer texv for hpos(t-1).

Behaviour:
- Reset: state=IDLE; hit=0, rgb=0, texv=0; latched line registers and accumulator are cleared.
- Line load:
  - line_start captures all *_in fields, tex_init and tex_step, and computes the span.
  - ws = (size > HALF) ? 0 : HALF-size.
  - we = min(HALF+size, H_VIEW-1).
  - Next state is PRE.
  - line_start in any state, including mid-wall, aborts the current line and reloads.
- States and transitions:
  - IDLE: outputs blank. Left only via line_start.
  - PRE: hpos < ws gives blank. When hpos == ws: acc <= tex_init + tex_step, the output pixel uses tex_init, state goes to WALL.
  - WALL: output pixel uses acc; acc <= acc + tex_step. On hpos == we, state goes to POST after emitting the pixel. If ws == we (size=0), PRE goes directly to POST with exactly one hit pixel at HALF.
  - POST: blank. On hpos == H_VIEW-1 or hpos >= H_VIEW, state goes to IDLE.
- Blank means hit=0, rgb=0, texv=0.
- Hit condition:
  - Identical to the legacy rule: (size > HALF) or (HALF-size <= hpos <= HALF+size), restricted to hpos < H_VIEW.
  - Comparisons are done in SIZE_W+1 bits, with no underflow.
- Accumulator:
  - TEX_W+FRAC_W bits, wraps modulo 2^(TEX_W+FRAC_W).
  - texv = acc[TEX_W+FRAC_W-1:FRAC_W], i.e. texture repeats.
  - For pixel p: texv = ((tex_init + (p-ws)*tex_step) >> FRAC_W) mod 2^TEX_W.
- Shading (hit pixels only, computed from registered texv, texu, side). Per channel c (R=0, G=1, B=2), where u_c = texu[2c mod TEX_W] and v_c = texv[2c mod TEX_W]:
  - mode 0 (flat): every channel = side ? all-ones : {1'b1, zeros}.
  - mode 1 (legacy xor): channel MSB = u_c ^ v_c, channel LSB = side; extra low bits (CH_W>2) are 0.
  - mode 2 (checker): c0 = texu[0]^texv[0]. G channel = c0 ? all-ones : 0; B channel = side ? all-ones : {1'b1, zeros}; R = 0.
  - mode 3 (debug gradient): each channel = texv[TEX_W-1 -: CH_W].
- Latency: exactly 1 clk from hpos to hit/rgb/texv. A mode change affects the output 1 clk later.
- Precondition: hpos must not skip values inside [ws, we]. If it does, the output is undefined until the next line_start; no lock-up is permitted.

Test Plan:
- Reset held 3 clks, mid-wall → hit=0, rgb=0, texv=0 the cycle after reset is sampled; IDLE until line_start.
- size=100, tex_init=0, tex_step=328, FRAC_W=10, hpos sweep 0..799 → hit=1 exactly for hpos 220..420, seen 1 clk later. texv=0 at hpos 220, 63 at hpos 419, wraps to 0 at hpos 420.
- size=0 → single hit pixel at hpos 320; size=400 with tex_init=80<<10 → hit for all 0..639, texv=16 at hpos 0, hit=0 for hpos ≥ 640.
- Mode sweep with side=1, texu=6'b000101, texv forced to 0 (tex_step=0), CH_W=2:
  - mode 1 → rgb=6'b01_11_11 (BB GG RR, each channel {u_c, side}).
  - mode 0 → 6'b111111.
  - mode 2 → 6'b11_11_00.
  - mode 3 → 6'b000000.
- line_start pulsed again after hpos 639 with size 50, then a line_start injected mid-wall with size 10 → second span 270..370 is correct; the reload aborts to PRE, and the next line hits only 310..330.
- CH_W=3, TEX_W=7 build, size=64, tex_step=1<<FRAC_W → texv increments by 1 per pixel from 0 at hpos 256 to 127 at hpos 383, wraps to 0 at hpos 384. rgb is 9 bits wide with the correct mode 3 gradient.
